// File: rtl/mdu_sequencer_pkg.sv
// Shared pipeline types: ALU and MDU operation encodings, MDU sequencer state
// and the default multiply/divide latencies.
package mdu_sequencer_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_NOR  = 3'd5,
    ALU_SLT  = 3'd6,
    ALU_SLTU = 3'd7
  } alu_operator_t;

  typedef enum logic [2:0] {
    READ_HI            = 3'd0,
    READ_LO            = 3'd1,
    WRITE_HI           = 3'd2,
    WRITE_LO           = 3'd3,
    START_SIGNED_MUL   = 3'd4,
    START_UNSIGNED_MUL = 3'd5,
    START_SIGNED_DIV   = 3'd6,
    START_UNSIGNED_DIV = 3'd7
  } mdu_operation_t;

  typedef enum logic [1:0] {
    MDU_IDLE     = 2'd0,
    MDU_MUL      = 2'd1,
    MDU_DIV_ITER = 2'd2,
    MDU_DIV_FIX  = 2'd3
  } mdu_state_t;

  localparam int MDU_MUL_CYCLES_DEFAULT    = 5;
  localparam int MDU_DIV_ITER_BITS_DEFAULT = 32;

  // Magnitude of a two's-complement word when negate_en is set, raw word otherwise.
  function automatic logic [31:0] abs32(input logic [31:0] value, input logic negate_en);
    logic [31:0] result;
    if (negate_en && value[31]) begin
      result = 32'd0 - value;
    end else begin
      result = value;
    end
    return result;
  endfunction

endpackage

// File: rtl/mdu_sequencer_serial_divider.sv
// Unsigned restoring divider: one quotient bit per cycle after a start pulse,
// done stays high from the final step until the next start.
module mdu_sequencer_serial_divider
  import mdu_sequencer_pkg::*;
#(
  parameter int ITER_BITS = MDU_DIV_ITER_BITS_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        done
);

  localparam int CW = $clog2(ITER_BITS + 1);

  logic [31:0]   rem_r;
  logic [31:0]   quot_r;
  logic [31:0]   divisor_r;
  logic [CW-1:0] count_r;
  logic          running_r;
  logic          done_r;
  logic [32:0]   shifted_s;
  logic [32:0]   diff_s;

  // Trial subtraction on the 33-bit shifted partial remainder.
  always_comb begin
    shifted_s = {rem_r, quot_r[31]};
    diff_s    = shifted_s - {1'b0, divisor_r};
  end

  // Iteration registers: load on start, one restoring step per running cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      rem_r     <= 32'd0;
      quot_r    <= 32'd0;
      divisor_r <= 32'd0;
      count_r   <= {CW{1'b0}};
      running_r <= 1'b0;
      done_r    <= 1'b0;
    end else if (start) begin
      rem_r     <= 32'd0;
      quot_r    <= dividend;
      divisor_r <= divisor;
      count_r   <= CW'(ITER_BITS);
      running_r <= 1'b1;
      done_r    <= 1'b0;
    end else if (running_r) begin
      if (diff_s[32]) begin
        rem_r  <= shifted_s[31:0];
        quot_r <= {quot_r[30:0], 1'b0};
      end else begin
        rem_r  <= diff_s[31:0];
        quot_r <= {quot_r[30:0], 1'b1};
      end
      count_r <= count_r - CW'(1);
      if (count_r == CW'(1)) begin
        running_r <= 1'b0;
        done_r    <= 1'b1;
      end else begin
        running_r <= 1'b1;
        done_r    <= 1'b0;
      end
    end else begin
      running_r <= 1'b0;
    end
  end

  assign quotient  = quot_r;
  assign remainder = rem_r;
  assign done      = done_r;

endmodule

// File: rtl/mdu_sequencer.sv
// EX-stage multiply/divide unit: owns HI/LO, sequences MULT/DIV over several
// cycles and requests a pipeline stall for any MDU instruction while busy.
module mdu_sequencer
  import mdu_sequencer_pkg::*;
#(
  parameter int MUL_CYCLES    = MDU_MUL_CYCLES_DEFAULT,
  parameter int DIV_ITER_BITS = MDU_DIV_ITER_BITS_DEFAULT
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           mdu_use,
  input  logic           mdu_start,
  input  mdu_operation_t mdu_operation,
  input  logic [31:0]    operand1,
  input  logic [31:0]    operand2,
  output logic           busy,
  output logic           stall_request,
  output logic [31:0]    data_read,
  output logic [31:0]    hi,
  output logic [31:0]    lo
);

  localparam int CNT_MAX = (MUL_CYCLES > DIV_ITER_BITS) ? MUL_CYCLES : DIV_ITER_BITS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  mdu_state_t       state_r;
  mdu_state_t       state_next_s;
  logic [CNT_W-1:0] count_r;
  logic [63:0]      product_r;
  logic [31:0]      hi_r;
  logic [31:0]      lo_r;
  logic             quot_neg_r;
  logic             rem_neg_r;
  logic             div_zero_r;

  logic             busy_s;
  logic             accept_s;
  logic             is_signed_s;
  logic             mul_start_s;
  logic             div_start_s;
  logic [31:0]      data_read_s;
  logic [63:0]      product_s;
  logic [31:0]      quotient_s;
  logic [31:0]      remainder_s;
  logic [31:0]      quot_fix_s;
  logic [31:0]      rem_fix_s;
  logic             div_done_s;

  mdu_sequencer_serial_divider #(
    .ITER_BITS (DIV_ITER_BITS)
  ) u_divider (
    .clock     (clock),
    .reset     (reset),
    .start     (div_start_s),
    .dividend  (abs32(operand1, is_signed_s)),
    .divisor   (abs32(operand2, is_signed_s)),
    .quotient  (quotient_s),
    .remainder (remainder_s),
    .done      (div_done_s)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= MDU_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      MDU_IDLE: begin
        if (mul_start_s) begin
          state_next_s = MDU_MUL;
        end else if (div_start_s) begin
          state_next_s = MDU_DIV_ITER;
        end else begin
          state_next_s = MDU_IDLE;
        end
      end
      MDU_MUL: begin
        if (count_r == {CNT_W{1'b0}}) begin
          state_next_s = MDU_IDLE;
        end else begin
          state_next_s = MDU_MUL;
        end
      end
      MDU_DIV_ITER: begin
        if (count_r == {CNT_W{1'b0}}) begin
          state_next_s = MDU_DIV_FIX;
        end else begin
          state_next_s = MDU_DIV_ITER;
        end
      end
      MDU_DIV_FIX: state_next_s = MDU_IDLE;
      default:     state_next_s = MDU_IDLE;
    endcase
  end

  // Handshake decode, read mux and start qualification.
  always_comb begin
    busy_s      = (state_r != MDU_IDLE);
    accept_s    = mdu_use && !busy_s;
    is_signed_s = (mdu_operation == START_SIGNED_MUL) || (mdu_operation == START_SIGNED_DIV);
    mul_start_s = accept_s && mdu_start &&
                  ((mdu_operation == START_SIGNED_MUL) || (mdu_operation == START_UNSIGNED_MUL));
    div_start_s = accept_s && mdu_start &&
                  ((mdu_operation == START_SIGNED_DIV) || (mdu_operation == START_UNSIGNED_DIV));
    case (mdu_operation)
      READ_HI: data_read_s = hi_r;
      READ_LO: data_read_s = lo_r;
      default: data_read_s = 32'd0;
    endcase
  end

  // Product and sign correction of the divider result.
  always_comb begin
    if (is_signed_s) begin
      product_s = {{32{operand1[31]}}, operand1} * {{32{operand2[31]}}, operand2};
    end else begin
      product_s = {32'd0, operand1} * {32'd0, operand2};
    end
    if (quot_neg_r) begin
      quot_fix_s = 32'd0 - quotient_s;
    end else begin
      quot_fix_s = quotient_s;
    end
    if (rem_neg_r) begin
      rem_fix_s = 32'd0 - remainder_s;
    end else begin
      rem_fix_s = remainder_s;
    end
  end

  // HI/LO, latched product, cycle counter and divide sign flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      hi_r       <= 32'd0;
      lo_r       <= 32'd0;
      product_r  <= 64'd0;
      count_r    <= {CNT_W{1'b0}};
      quot_neg_r <= 1'b0;
      rem_neg_r  <= 1'b0;
      div_zero_r <= 1'b0;
    end else begin
      case (state_r)
        MDU_IDLE: begin
          if (mul_start_s) begin
            product_r <= product_s;
            count_r   <= CNT_W'(MUL_CYCLES - 1);
          end else if (div_start_s) begin
            count_r    <= CNT_W'(DIV_ITER_BITS - 1);
            quot_neg_r <= is_signed_s && (operand1[31] ^ operand2[31]);
            rem_neg_r  <= is_signed_s && operand1[31];
            div_zero_r <= (operand2 == 32'd0);
          end else if (accept_s && (mdu_operation == WRITE_HI)) begin
            hi_r <= operand1;
          end else if (accept_s && (mdu_operation == WRITE_LO)) begin
            lo_r <= operand1;
          end
        end
        MDU_MUL: begin
          if (count_r == {CNT_W{1'b0}}) begin
            hi_r <= product_r[63:32];
            lo_r <= product_r[31:0];
          end else begin
            count_r <= count_r - CNT_W'(1);
          end
        end
        MDU_DIV_ITER: begin
          if (count_r != {CNT_W{1'b0}}) begin
            count_r <= count_r - CNT_W'(1);
          end
        end
        MDU_DIV_FIX: begin
          // A zero divisor runs the full latency but leaves HI/LO untouched.
          if (div_done_s && !div_zero_r) begin
            lo_r <= quot_fix_s;
            hi_r <= rem_fix_s;
          end
        end
        default: begin
          count_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign busy          = busy_s;
  assign stall_request = mdu_use && busy_s;
  assign data_read     = data_read_s;
  assign hi            = hi_r;
  assign lo            = lo_r;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: hand-computed HI/LO results, busy
// latencies, stall lengths and reset-abandon behaviour.
module tb_mdu_sequencer;
  import mdu_sequencer_pkg::*;

  logic           clock = 1'b0;
  logic           reset;
  logic           mdu_use;
  logic           mdu_start;
  mdu_operation_t mdu_operation;
  logic [31:0]    operand1;
  logic [31:0]    operand2;
  logic           busy;
  logic           stall_request;
  logic [31:0]    data_read;
  logic [31:0]    hi;
  logic [31:0]    lo;

  int vectors     = 0;
  int miscompares = 0;
  int n;

  always #5 clock = ~clock;

  mdu_sequencer dut (
    .clock         (clock),
    .reset         (reset),
    .mdu_use       (mdu_use),
    .mdu_start     (mdu_start),
    .mdu_operation (mdu_operation),
    .operand1      (operand1),
    .operand2      (operand2),
    .busy          (busy),
    .stall_request (stall_request),
    .data_read     (data_read),
    .hi            (hi),
    .lo            (lo)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input mdu_operation_t op, input logic [31:0] a, input logic [31:0] b);
    mdu_use       = 1'b1;
    mdu_start     = op inside {START_SIGNED_MUL, START_UNSIGNED_MUL, START_SIGNED_DIV, START_UNSIGNED_DIV};
    mdu_operation = op;
    operand1      = a;
    operand2      = b;
    tick();
    mdu_use   = 1'b0;
    mdu_start = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 200) begin
      cycles++;
      tick();
    end
  endtask

  task automatic count_stalls(output int cycles);
    cycles = 0;
    while (stall_request === 1'b1 && cycles < 200) begin
      cycles++;
      tick();
    end
  endtask

  initial begin
    reset         = 1'b1;
    mdu_use       = 1'b0;
    mdu_start     = 1'b0;
    mdu_operation = READ_HI;
    operand1      = 32'd0;
    operand2      = 32'd0;
    tick();
    tick();
    reset = 1'b0;
    check_eq("reset_busy", {31'd0, busy}, 32'd0);
    check_eq("reset_stall", {31'd0, stall_request}, 32'd0);
    check_eq("reset_hi", hi, 32'd0);
    check_eq("reset_lo", lo, 32'd0);
    check_eq("reset_data_read", data_read, 32'd0);

    // Preload HI/LO, then abandon a divide at busy cycle 10 with reset.
    issue(WRITE_LO, 32'h0000_0055, 32'd0);
    issue(WRITE_HI, 32'h0000_0066, 32'd0);
    check_eq("mtlo_lo", lo, 32'h0000_0055);
    check_eq("mthi_hi", hi, 32'h0000_0066);
    issue(START_SIGNED_DIV, 32'd100, 32'd3);
    repeat (9) tick();
    check_eq("div_busy_c10", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("rst_mid_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_mid_hi", hi, 32'd0);
    check_eq("rst_mid_lo", lo, 32'd0);
    mdu_use       = 1'b1;
    mdu_operation = READ_LO;
    #1;
    check_eq("rst_mflo_data", data_read, 32'd0);
    check_eq("rst_mflo_stall", {31'd0, stall_request}, 32'd0);
    mdu_use = 1'b0;
    repeat (40) tick();
    check_eq("rst_late_hi", hi, 32'd0);
    check_eq("rst_late_lo", lo, 32'd0);

    issue(START_SIGNED_MUL, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    check_eq("mult_busy_cycles", n, 32'd5);
    check_eq("mult_hi", hi, 32'hFFFF_FFFF);
    check_eq("mult_lo", lo, 32'hFFFF_FFFA);

    issue(START_UNSIGNED_MUL, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    check_eq("multu_busy_cycles", n, 32'd5);
    check_eq("multu_hi", hi, 32'h0000_0002);
    check_eq("multu_lo", lo, 32'hFFFF_FFFA);

    issue(START_SIGNED_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    check_eq("div_busy_cycles", n, 32'd33);
    check_eq("div_lo", lo, 32'hFFFF_FFFD);
    check_eq("div_hi", hi, 32'hFFFF_FFFF);

    issue(START_UNSIGNED_DIV, 32'd7, 32'd2);
    wait_idle(n);
    check_eq("divu_busy_cycles", n, 32'd33);
    check_eq("divu_data_nonread", data_read, 32'd0);
    mdu_operation = READ_LO;
    #1;
    check_eq("divu_lo_read", data_read, 32'd3);
    check_eq("divu_hi", hi, 32'd1);

    issue(WRITE_LO, 32'h0000_1234, 32'd0);
    check_eq("mtlo_1234", lo, 32'h0000_1234);
    issue(START_SIGNED_DIV, 32'd5, 32'd0);
    wait_idle(n);
    check_eq("div0_busy_cycles", n, 32'd33);
    check_eq("div0_lo", lo, 32'h0000_1234);
    check_eq("div0_hi", hi, 32'd1);

    issue(START_SIGNED_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    check_eq("divmin_lo", lo, 32'h8000_0000);
    check_eq("divmin_hi", hi, 32'd0);

    // MFHI presented two cycles after the MULT start cycle.
    issue(START_SIGNED_MUL, 32'h0001_0000, 32'h0003_0000);
    tick();
    tick();
    mdu_use       = 1'b1;
    mdu_operation = READ_HI;
    #1;
    count_stalls(n);
    check_eq("mfhi_stall_cycles", n, 32'd3);
    check_eq("mfhi_data", data_read, 32'd3);
    check_eq("mfhi_lo", lo, 32'd0);
    mdu_use = 1'b0;

    // Back-to-back MULTs: second waits, then overwrites the first.
    issue(START_SIGNED_MUL, 32'd2, 32'd3);
    mdu_use       = 1'b1;
    mdu_start     = 1'b1;
    mdu_operation = START_SIGNED_MUL;
    operand1      = 32'd4;
    operand2      = 32'd5;
    #1;
    count_stalls(n);
    check_eq("b2b_stall_cycles", n, 32'd5);
    check_eq("b2b_first_lo", lo, 32'd6);
    tick();
    mdu_use   = 1'b0;
    mdu_start = 1'b0;
    wait_idle(n);
    check_eq("b2b_second_busy", n, 32'd5);
    check_eq("b2b_second_lo", lo, 32'd20);
    check_eq("b2b_second_hi", hi, 32'd0);

    // MTLO held off by a running MULT lands after the product.
    issue(START_SIGNED_MUL, 32'd2, 32'd3);
    mdu_use       = 1'b1;
    mdu_operation = WRITE_LO;
    operand1      = 32'h0000_0077;
    #1;
    count_stalls(n);
    check_eq("mtlo_stall_cycles", n, 32'd5);
    tick();
    mdu_use = 1'b0;
    check_eq("mtlo_after_mul_lo", lo, 32'h0000_0077);
    check_eq("mtlo_after_mul_hi", hi, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Multi-cycle multiply/divide responder at the far end of the controller's MDU control bundle (operation, use, start) in the EX stage.
- Owns the HI/LO architectural registers and runs MULT/MULTU and DIV/DIVU to completion over several cycles.
- Raises a stall request whenever an MDU instruction arrives while a computation is still in flight.
- Serves MFHI/MFLO reads and MTHI/MTLO writes.

Parameters:
- MUL_CYCLES, 5, cycles busy is held high after a multiply start (>=1).
- DIV_ITER_BITS, 32, quotient bits produced by the divider; fixed at 32, exposed only for bench shortening.

Ports:
- clock  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state
- mdu_use  input  1  EX-stage instruction is an MDU instruction
- mdu_start  input  1  EX-stage instruction is MULT/MULTU/DIV/DIVU
- mdu_operation  input  3  mdu_operation_t: READ_HI, READ_LO, WRITE_HI, WRITE_LO, START_SIGNED_MUL, START_UNSIGNED_MUL, START_SIGNED_DIV, START_UNSIGNED_DIV
- operand1  input  32  rs value (multiplicand/dividend, MTHI/MTLO data)
- operand2  input  32  rt value (multiplier/divisor)
- busy  output  1  computation in flight
- stall_request  output  1  mdu_use && busy; holds IF/ID/EX
- data_read  output  32  HI for READ_HI, LO for READ_LO, else 0
- hi  output  32  current HI
- lo  output  32  current LO

Behaviour:
- Reset values: busy=0, stall_request=0, hi=0, lo=0, data_read=0; FSM in IDLE, counter 0. A reset mid-operation abandons the computation; no partial write to HI/LO.
- FSM states:
  - IDLE, MUL, DIV_ITER, DIV_FIX.
  - busy = (state != IDLE).
- Accepted command: an operation is accepted only when mdu_use=1 and busy=0. When busy=1, all inputs are ignored and stall_request=1. The pipeline re-presents the same instruction later.
- Reads: data_read is combinational from the current hi/lo registers. It is valid only when not stalled.
- MTHI/MTLO: on acceptance, hi (or lo) <= operand1 at that edge. The other register is unchanged. State stays IDLE.
- Multiply start:
  - Latch the 64-bit product (signed or unsigned per op); counter <= MUL_CYCLES-1; go to MUL.
  - busy is high for exactly MUL_CYCLES cycles after the start edge.
  - On the edge leaving MUL: {hi,lo} <= product, then IDLE.
- Divide start:
  - Latch |operand1|, |operand2| (raw operands if unsigned) and the sign flags; go to DIV_ITER.
  - DIV_ITER runs one restoring step per cycle for DIV_ITER_BITS cycles.
  - DIV_FIX applies sign correction (quotient negated if signs differ; remainder takes the dividend's sign), writes lo <= quotient and hi <= remainder, then goes to IDLE.
  - Total busy = DIV_ITER_BITS+1 cycles (33 by default).
- Divide by zero: same timing, but hi/lo are left unchanged at DIV_FIX.
- Signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Same edge as completion: busy=1 during the final busy cycle, so a new command presented then stalls. It is accepted in the first IDLE cycle.
- MTHI/MTLO issued during busy stalls. No write is lost or reordered.
- Arithmetic:
  - All widths 32 bit; the product is 64 bit.
  - Divider remainder register is 33 bit during iteration.

Decomposition:
- mdu_operation_t, state enum, and the MUL_CYCLES/DIV_ITER_BITS defaults go in the shared pipeline package, next to alu_operator_t.
- One sub-module, serial_divider: unsigned restoring divider with start/done handshake, 32-bit quotient/remainder, one bit per cycle.
- mdu_sequencer owns signing, the multiply path, HI/LO and stall.

Test Plan:
- Reset mid-DIV (cycle 10) -> hi=lo=0, busy=0 the next cycle; a following MFLO reads 0.
- MULT 0xFFFFFFFE x 3 -> busy for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV -7/2 -> 33 busy cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1.
- MTLO 0x1234 then DIV 5/0 -> after 33 cycles lo=0x1234 and hi unchanged.
- MFHI issued 2 cycles after a MULT start -> stall_request=1 for 3 cycles. Then data_read equals the new hi.
- Back-to-back MULT, MULT -> the second is stalled until busy drops, and its result overwrites the first.
